// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_pkg
// Purpose  : Shared types and constants for the accumulating arbiter.
// Revision : 1.0  initial release
// ============================================================================
package acc_pkg;

    // Default parameter values for acc_arbiter
    localparam int DEF_NREQ = 4;
    localparam int DEF_DW   = 8;
    localparam int DEF_SW   = 16;

    // Beat counter width and its saturation value
    localparam int                BEAT_W   = 8;
    localparam logic [BEAT_W-1:0] BEAT_MAX = {BEAT_W{1'b1}};

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage : acc_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first asserted
//            request at or after the pointer, wrapping past NREQ-1 to 0.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   winner_o,
    output logic            any_o
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest valid request wins
    always_comb begin
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_i[idx]) begin
                winner_o = IW'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/acc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : acc_arbiter
// Purpose  : Round-robin arbiter that grants one requester at a time for a
//            whole packet, sums the packet's samples and hands out a single
//            result (sum, owner, beat count, overflow) per packet.
// Revision : 1.0  initial release
// ============================================================================
module acc_arbiter
    import acc_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int SW   = DEF_SW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [SW-1:0]           res_sum,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [BEAT_W-1:0]       res_beats,
    output logic                    res_ovf,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);

    state_t            state_q,  state_d;
    logic [IW-1:0]     grant_q,  grant_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]     sum_q,    sum_d;
    logic [BEAT_W-1:0] beats_q,  beats_d;
    logic              ovf_q,    ovf_d;

    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [DW-1:0]     beat_data;
    logic              beat_fire;
    logic [SW:0]       add_full;
    logic [IW-1:0]     grant_next;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .winner_o (pick_idx),
        .any_o    (pick_any)
    );

    // Datapath terms for the granted requester's current beat
    always_comb begin
        beat_data  = req_data[int'(grant_q)*DW +: DW];
        beat_fire  = (state_q == ACC) && req_valid[grant_q];
        add_full   = {1'b0, sum_q} + {{(SW + 1 - DW){1'b0}}, beat_data};
        grant_next = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
    end

    // Next-state and accumulator update logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        sum_d    = sum_q;
        beats_d  = beats_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (beat_fire) begin
                    // A zero beat count marks the first beat of the packet
                    if (beats_q == '0) begin
                        sum_d = SW'(beat_data);
                    end else begin
                        sum_d = add_full[SW-1:0];
                        ovf_d = ovf_q | add_full[SW];
                    end
                    if (beats_q != BEAT_MAX) begin
                        beats_d = beats_q + BEAT_W'(1);
                    end
                    if (req_last[grant_q]) begin
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_next;
                    sum_d    = '0;
                    beats_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and accumulator registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            sum_q    <= '0;
            beats_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            sum_q    <= sum_d;
            beats_q  <= beats_d;
            ovf_q    <= ovf_d;
        end
    end

    // Only the granted requester sees ready, and only while accumulating
    always_comb begin
        req_ready = '0;
        if (state_q == ACC) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    // Result outputs come straight from the held registers
    always_comb begin
        res_valid = (state_q == RESULT);
        res_sum   = sum_q;
        res_id    = grant_q;
        res_beats = beats_q;
        res_ovf   = ovf_q;
        busy      = (state_q != IDLE);
    end

endmodule : acc_arbiter
`default_nettype wire
